// File: rtl/vram_vga_reader.sv
// Display-side VRAM reader: generates VGA raster timing from clk_i with a pixel
// strobe divider, fetches 2x-upscaled pixels from VRAM and drives RGB plus syncs.
module vram_vga_reader #(
    parameter int   CLK_DIV      = 4,
    parameter int   READ_LATENCY = 1,
    parameter int   H_ACTIVE     = 640,
    parameter int   H_FP         = 16,
    parameter int   H_SYNC       = 96,
    parameter int   H_BP         = 48,
    parameter int   V_ACTIVE     = 480,
    parameter int   V_FP         = 10,
    parameter int   V_SYNC       = 2,
    parameter int   V_BP         = 33,
    parameter logic SYNC_POL     = 1'b0,
    parameter int   ADDR_WIDTH   = 17,
    parameter int   DATA_WIDTH   = 12
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] pixel_data_i,
    output logic [ADDR_WIDTH-1:0] pixel_read_address_o,
    output logic [3:0]            vga_r_o,
    output logic [3:0]            vga_g_o,
    output logic [3:0]            vga_b_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  video_active_o,
    output logic                  frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    // Divider must span a full pixel period, which always exceeds the read latency.
    localparam int DIV_W   = $clog2((CLK_DIV > READ_LATENCY) ? CLK_DIV : READ_LATENCY + 1);

    localparam logic [DIV_W-1:0]      DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]        H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]        H_ACT      = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]        HS_FIRST   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]        HS_LAST    = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0]        V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]        V_ACT      = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]        VS_FIRST   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]        VS_LAST    = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(H_ACTIVE / 2);

    logic [DIV_W-1:0]      divider_q, divider_d;
    logic [H_W-1:0]        h_q, h_d;
    logic [V_W-1:0]        v_q, v_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            r_q, r_d, g_q, g_d, b_q, b_d;
    logic                  hsync_q, hsync_d, vsync_q, vsync_d;
    logic                  active_q, active_d, frame_start_q, frame_start_d;
    logic                  tick, prev_active;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        divider_d     = divider_q + DIV_W'(1);
        h_d           = h_q;
        v_d           = v_q;
        row_base_d    = row_base_q;
        addr_d        = addr_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        frame_start_d = 1'b0;
        tick          = (divider_q == DIV_LAST);
        prev_active   = (h_q < H_ACT) && (v_q < V_ACT);

        if (tick) begin
            divider_d = '0;
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d           = '0;
                    row_base_d    = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_d = v_q + V_W'(1);
                    // Each VRAM row is shown on two display lines; step after the second.
                    if (v_q[0] && (v_q < V_ACT))
                        row_base_d = row_base_q + ROW_STRIDE;
                end
            end else begin
                h_d = h_q + H_W'(1);
            end

            if ((h_d < H_ACT) && (v_d < V_ACT))
                addr_d = row_base_d + ADDR_WIDTH'(h_d >> 1);
            else
                addr_d = '0;

            // Output stage shows the pixel whose address was issued one period ago.
            active_d = prev_active;
            r_d      = prev_active ? pixel_data_i[11:8] : 4'h0;
            g_d      = prev_active ? pixel_data_i[7:4]  : 4'h0;
            b_d      = prev_active ? pixel_data_i[3:0]  : 4'h0;
            hsync_d  = ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
            vsync_d  = ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        if (reset_i) begin
            divider_q     <= '0;
            h_q           <= '0;
            v_q           <= '0;
            row_base_q    <= '0;
            addr_q        <= '0;
            r_q           <= 4'h0;
            g_q           <= 4'h0;
            b_q           <= 4'h0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            divider_q     <= divider_d;
            h_q           <= h_d;
            v_q           <= v_d;
            row_base_q    <= row_base_d;
            addr_q        <= addr_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_read_address_o = addr_q;
    assign vga_r_o              = r_q;
    assign vga_g_o              = g_q;
    assign vga_b_o              = b_q;
    assign hsync_o              = hsync_q;
    assign vsync_o              = vsync_q;
    assign video_active_o       = active_q;
    assign frame_start_o        = frame_start_q;

endmodule

// File: doc/vram_vga_reader.md
Name: vram_vga_reader

Overview:
Display-side reader for the camera VRAM. It generates 640x480@60 VGA timing from the system clock and derives a pixel strobe from that clock. It issues read addresses into the read port of the dual-clock VRAM, which is 320x240, 12-bit RGB444, one read-cycle latency, and drives 2x-upscaled RGB plus sync to the VGA pins. The block sits between the VRAM read port and the board VGA connector, entirely in the clk_i domain.

Parameters:
- CLK_DIV, 4: clk_i cycles per pixel; must be > READ_LATENCY.
- READ_LATENCY, 1: VRAM read latency in clk_i cycles.
- H_ACTIVE, 640
- H_FP, 16
- H_SYNC, 96
- H_BP, 48
- V_ACTIVE, 480
- V_FP, 10
- V_SYNC, 2
- V_BP, 33
- SYNC_POL, 0: sync asserted level; 0 = active low.
- ADDR_WIDTH, 17: VRAM address width; $clog2(76800).
- DATA_WIDTH, 12: VRAM word width, {R[11:8],G[7:4],B[3:0]}.

Ports:
- clk_i  in  1  system clock; only clock.
- reset_i  in  1  synchronous, active-high reset.
- pixel_data_i  in  DATA_WIDTH  VRAM read data.
- pixel_read_address_o  out  ADDR_WIDTH  VRAM read address.
- vga_r_o  out  4  red.
- vga_g_o  out  4  green.
- vga_b_o  out  4  blue.
- hsync_o  out  1  horizontal sync.
- vsync_o  out  1  vertical sync.
- video_active_o  out  1  high while RGB outputs carry an active pixel.
- frame_start_o  out  1  one-clk pulse at the start of each frame.

Behaviour:
- Clock and reset: one clock, clk_i; reset_i is synchronous and active-high. Every register updates only on posedge clk_i.
- Reset values:
  - divider = 0, h = 0, v = 0.
  - pixel_read_address_o = 0.
  - vga_r/g/b_o = 0.
  - hsync_o = vsync_o = ~SYNC_POL.
  - video_active_o = 0, frame_start_o = 0.
- Reset mid-operation: reset_i wins over any other event. On the next edge all state takes reset values and the raster restarts at (0,0).
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - Internal tick is asserted in the cycle where divider == CLK_DIV-1.
  - First tick occurs CLK_DIV cycles after reset release.
  - Nothing below advances except on a tick.
- Counters: H_TOTAL = 800, V_TOTAL = 525.
  - On tick, h increments.
  - When h == H_TOTAL-1: h -> 0 and v increments.
  - When also v == V_TOTAL-1: v -> 0.
- Address, registered on the same tick as the counter update and computed from the new (h,v):
  - Active region (h < H_ACTIVE and v < V_ACTIVE): address = (v>>1)*(H_ACTIVE/2) + (h>>1).
  - Outside the active region: address = 0.
  - Implement incrementally, with no multiplier: keep a row-base register that advances by H_ACTIVE/2 after each odd active line and resets at frame wrap.
- Data/output stage: updates on every tick and reflects the (h,v) of the previous pixel period, so outputs lag the counters by exactly one pixel period (CLK_DIV clocks).
  - Data is captured from pixel_data_i at the tick. It is valid because CLK_DIV > READ_LATENCY.
  - video_active_o = prev-active.
  - RGB = pixel_data_i fields when prev-active, else 0.
  - hsync_o = SYNC_POL when prev h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751]; else ~SYNC_POL.
  - vsync_o = SYNC_POL when prev v is in [490,491]; else ~SYNC_POL.
- frame_start_o:
  - High for exactly one clk, on the tick where the counters wrap to (0,0).
  - Low otherwise.
  - Not asserted for the reset-initial (0,0).
- Outputs hold their values between ticks.
- No handshake is used on the VRAM read port; its read enable is tied high externally.

Test Plan:
1. Reset: hold reset_i 3 clks, then release -> hsync_o = vsync_o = 1, RGB = 0, address = 0. First tick at clk 4 after release, then every 4 clks.
2. Address mapping:
   - (h,v) = (2,0) -> 1
   - (639,0) -> 319
   - (0,1) -> 0
   - (0,2) -> 320
   - (639,479) -> 76799
   - (640,0) -> 0
3. Hsync: hsync_o low for 96 consecutive ticks (384 clks) starting one pixel period after h = 656; line period 800 ticks = 3200 clks.
4. Vsync and frame:
   - vsync_o low for 2 lines (1600 ticks) starting with line 490.
   - frame_start_o pulses every 420000 ticks = 1,680,000 clks, each pulse exactly 1 clk wide.
5. Data path: pixel_data_i = 12'hA5C held constant -> r = A, g = 5, b = C on active pixels; r = g = b = 0 and video_active_o = 0 for h >= 640 or v >= 480.
6. Reset mid-frame: assert reset_i at (h,v) = (300,200) -> next clk all outputs at reset values. After release the raster restarts at (0,0) and address sequence 0,0,1,1,... is observed.
